// File: rtl/baud_pkg.sv
// baud_pkg: register addresses and standard divisor constants for baud_rate_gen
package baud_pkg;
  localparam logic [1:0] BAUD_ADDR_FRAC = 2'b01;
  localparam logic [1:0] BAUD_ADDR_LO   = 2'b10;
  localparam logic [1:0] BAUD_ADDR_HI   = 2'b11;
  localparam int BAUD_DIV_4800  = 650;
  localparam int BAUD_DIV_9600  = 325;
  localparam int BAUD_DIV_19200 = 162;
  localparam int BAUD_DIV_38400 = 80;
endpackage

// File: rtl/baud_phase_cnt.sv
// baud_phase_cnt: counts rx ticks modulo OSR and flags the wrapping tick as tx_tick
// ports: clk, rst (sync active-high), clr (restart phase), rx_tick in, tx_tick out
module baud_phase_cnt #(
  parameter int OSR = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic rx_tick,
  output logic tx_tick
);
  localparam int PW = $clog2(OSR);
  logic [PW-1:0] phase;
  assign tx_tick = rx_tick && phase == PW'(OSR - 1);
  always_ff @(posedge clk) begin
    if (rst || clr) phase <= '0;
    else if (rx_tick) phase <= phase + PW'(1);
  end
endmodule

// File: rtl/baud_rate_gen.sv
// baud_rate_gen: programmable divisor producing rx oversample ticks and tx bit ticks
// ports: clk, rst (sync active-high), wr_en/ioaddr/wr_data register writes,
//        rx_tick, tx_tick one-cycle enables, div_q active divisor
// optional: define BAUD_FRAC_EN for a 4-bit fractional divisor at BAUD_ADDR_FRAC
module baud_rate_gen
  import baud_pkg::*;
#(
  parameter int DIV_W     = 16,
  parameter int OSR       = 16,
  parameter int RESET_DIV = 325
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [1:0]       ioaddr,
  input  logic [7:0]       wr_data,
  output logic             rx_tick,
  output logic             tx_tick,
  output logic [DIV_W-1:0] div_q
);
  localparam int NB = DIV_W / 8;
  logic [DIV_W-1:0] d, stage, cnt, new_d;
  logic [1:0] ptr;
  logic commit, lo_wr, hold;
  assign commit = wr_en && ioaddr == BAUD_ADDR_HI;
  assign lo_wr  = wr_en && ioaddr == BAUD_ADDR_LO;
  assign new_d  = (stage & ({DIV_W{1'b1}} >> 8)) | (DIV_W'(wr_data) << (DIV_W - 8));
  assign div_q  = d;
  assign rx_tick = !rst && !commit && !hold && cnt == '0;
`ifdef BAUD_FRAC_EN
  logic [3:0] f_pend, f, acc;
  logic [4:0] acc_sum;
  logic ext;
  assign acc_sum = {1'b0, acc} + {1'b0, f};
  assign hold = ext;
  // a carry out of the accumulator stalls the counter for one extra cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      f_pend <= '0;
      f      <= '0;
      acc    <= '0;
      ext    <= 1'b0;
    end else begin
      if (wr_en && ioaddr == BAUD_ADDR_FRAC) f_pend <= wr_data[3:0];
      if (commit) begin
        f   <= f_pend;
        acc <= '0;
        ext <= 1'b0;
      end else if (ext) ext <= 1'b0;
      else if (rx_tick) begin
        acc <= acc_sum[3:0];
        ext <= acc_sum[4];
      end
    end
  end
`else
  assign hold = 1'b0;
`endif
  // lower divisor bytes are staged low-to-high; the top-byte write commits them together
  always_ff @(posedge clk) begin
    if (rst) begin
      d     <= DIV_W'(RESET_DIV);
      stage <= DIV_W'(RESET_DIV);
      cnt   <= DIV_W'(RESET_DIV);
      ptr   <= '0;
    end else begin
      if (lo_wr) begin
        stage <= (stage & ~(DIV_W'(8'hff) << {ptr, 3'b000})) | (DIV_W'(wr_data) << {ptr, 3'b000});
        ptr   <= (int'(ptr) + 2 >= NB) ? ptr : ptr + 2'd1;
      end
      if (commit) begin
        d   <= new_d;
        cnt <= new_d;
        ptr <= '0;
      end else if (rx_tick) cnt <= d;
      else if (!hold) cnt <= cnt - DIV_W'(1);
    end
  end
  baud_phase_cnt #(.OSR(OSR)) u_phase (
    .clk    (clk),
    .rst    (rst),
    .clr    (commit),
    .rx_tick(rx_tick),
    .tx_tick(tx_tick)
  );
endmodule

// File: tb/tb_baud_rate_gen.sv
// tb_baud_rate_gen: period-level reference model checked every cycle, plus directed literal checks
module tb_baud_rate_gen;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic wr_en = 1'b0;
  logic [1:0] ioaddr = 2'b00;
  logic [7:0] wr_data = 8'h00;
  logic rx_tick, tx_tick;
  logic [15:0] div_q;
  int vectors = 0, errors = 0;
  bit chk_en = 1'b0;
  // model: divisor, staged low byte, cycles into current period, period length,
  // rx ticks since commit, fraction accumulator, pending/active fraction
  int md = 325, stg = 325 % 256, el = 0, len = 326, nrx = 0, acc = 0, fp = 0, mf = 0;

  baud_rate_gen dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .ioaddr(ioaddr), .wr_data(wr_data),
    .rx_tick(rx_tick), .tx_tick(tx_tick), .div_q(div_q)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      bit commit, exp_rx, exp_tx;
      commit = wr_en && ioaddr == 2'b11;
      exp_rx = !rst && !commit && el == len - 1;
      exp_tx = exp_rx && (nrx % 16) == 15;
      check("rx_tick", int'(rx_tick), int'(exp_rx));
      check("tx_tick", int'(tx_tick), int'(exp_tx));
      check("div_q", int'(div_q), md);
      if (rst) begin
        md = 325; stg = 325 % 256; el = 0; len = 326; nrx = 0; acc = 0; fp = 0; mf = 0;
      end else begin
        if (wr_en && ioaddr == 2'b10) stg = wr_data;
`ifdef BAUD_FRAC_EN
        if (wr_en && ioaddr == 2'b01) fp = wr_data[3:0];
`endif
        if (commit) begin
          md = wr_data * 256 + stg; mf = fp; el = 0; len = md + 1; nrx = 0; acc = 0;
        end else if (exp_rx) begin
          nrx++;
          acc += mf;
          len = md + 1 + (acc >= 16 ? 1 : 0);
          acc %= 16;
          el = 0;
        end else el++;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [7:0] d);
    wr_en = 1'b1; ioaddr = a; wr_data = d;
    step();
    wr_en = 1'b0; ioaddr = 2'b00;
  endtask

  // cycles until next rx tick (0 on timeout), leaves caller just after that tick's edge
  task automatic measure_rx(output int t, input int bound);
    t = 0;
    for (int n = 1; n <= bound; n++) begin
      @(negedge clk);
      if (rx_tick) begin t = n; break; end
    end
    step();
  endtask

  task automatic measure(output int t_rx, output int t_tx, input int bound);
    t_rx = 0; t_tx = 0;
    for (int n = 1; n <= bound; n++) begin
      @(negedge clk);
      if (rx_tick && t_rx == 0) t_rx = n;
      if (tx_tick) begin t_tx = n; break; end
    end
    step();
  endtask

  initial begin
    int r, t, sum;
    @(posedge clk);
    chk_en = 1'b1;
    #1;
    step(); step();
    rst = 1'b0;
    measure(r, t, 6000);
    check("reset_first_rx", r, 326);
    check("reset_first_tx", t, 5216);
    measure_rx(r, 400);
    check("reset_rx_period", r, 326);

    wr(2'b10, 8'h05);
    check("staging_div_q", int'(div_q), 325);
    measure_rx(r, 400);
    measure_rx(r, 400);
    check("staging_rx_period", r, 326);

    repeat (37) step();
    wr(2'b10, 8'h50);
    wr(2'b11, 8'h00);
    check("commit_div_q", int'(div_q), 80);
    measure(r, t, 2000);
    check("commit_first_rx", r, 81);
    check("commit_first_tx", t, 1296);
    measure_rx(r, 200);
    check("commit_rx_period", r, 81);

    wr(2'b00, 8'h07);
    check("addr00_ignored", int'(div_q), 80);

    wr(2'b10, 8'h00);
    wr(2'b11, 8'h00);
    check("zero_div_q", int'(div_q), 0);
    measure(r, t, 100);
    check("zero_first_rx", r, 1);
    check("zero_first_tx", t, 16);
    measure(r, t, 100);
    check("zero_tx_period", t, 16);

    rst = 1'b1; wr_en = 1'b1; ioaddr = 2'b11; wr_data = 8'h01;
    step();
    rst = 1'b0; wr_en = 1'b0; ioaddr = 2'b00;
    check("rst_prec_div_q", int'(div_q), 325);
    measure_rx(r, 400);
    check("rst_prec_rx", r, 326);

`ifdef BAUD_FRAC_EN
    wr(2'b01, 8'h08);
    wr(2'b10, 8'd80);
    wr(2'b11, 8'h00);
    measure_rx(r, 200);
    check("frac_first_rx", r, 81);
    sum = 0;
    for (int i = 0; i < 16; i++) begin
      measure_rx(r, 200);
      if (i < 2) check("frac_period", r, i == 0 ? 81 : 82);
      sum += r;
    end
    check("frac_sum16", sum, 1304);
    rst = 1'b1;
    step();
    rst = 1'b0;
`endif

    for (int i = 0; i < 4000; i++) begin
      int op;
      op = int'($urandom_range(0, 99));
      if (op < 1) begin
        rst = 1'b1; step(); rst = 1'b0;
      end else if (op < 8) begin
        logic [1:0] a;
        logic [7:0] d;
        a = 2'($urandom_range(0, 3));
        d = (a == 2'b11) ? 8'($urandom_range(0, 1) == 0 ? 0 : $urandom_range(0, 1))
                         : 8'($urandom_range(0, 40));
        wr(a, d);
      end else step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule

// File: doc/baud_rate_gen.md
BAUD_RATE_GEN -- requirements
Module: baud_rate_gen

Interface
REQ-001 SHALL have parameter DIV_W, default 16, meaning divisor register width (8..24, multiple of 8).
REQ-002 SHALL have parameter OSR, default 16, meaning receive oversample ticks per transmit tick (power of 2, 4..32).
REQ-003 SHALL have parameter RESET_DIV, default 325, meaning divisor after reset (9600 baud at 50 MHz, OSR 16).
REQ-004 SHALL have port clk, input, 1, meaning sole clock; all logic on posedge.
REQ-005 SHALL have port rst, input, 1, meaning synchronous active-high reset.
REQ-006 SHALL have port wr_en, input, 1, meaning register write strobe, one write per asserted cycle.
REQ-007 SHALL have port ioaddr, input, 2, meaning register select: 2'b10 divisor byte low, 2'b11 divisor byte high/commit, 2'b01 fraction (macro-gated); other values ignored.
REQ-008 SHALL have port wr_data, input, 8, meaning write data.
REQ-009 SHALL have port rx_tick, output, 1, meaning one-cycle oversample enable.
REQ-010 SHALL have port tx_tick, output, 1, meaning one-cycle bit-rate enable.
REQ-011 SHALL have port div_q, output, DIV_W, meaning currently active divisor.

Function
REQ-012 SHALL hold active divisor D and a DIV_W-bit down counter; rx_tick is asserted in the cycle the counter equals 0, and the counter reloads D on that cycle, else decrements; period = D+1 cycles.
REQ-013 SHALL give D=0 a rx_tick every cycle.
REQ-014 SHALL count rx_ticks modulo OSR; tx_tick is asserted coincident with the rx_tick that wraps the phase count from OSR-1 to 0; period = OSR*(D+1) cycles.
REQ-015 SHALL write byte ioaddr 2'b10 and, for DIV_W>16, intermediate bytes in the order low-to-high into a staging register only; active D is unaffected.
REQ-016 SHALL, on a write to 2'b11, load the top byte from wr_data and all lower bytes from staging into D atomically in the next cycle.
REQ-017 SHALL, on commit, reload the counter with the new D, clear the phase count, and suppress rx_tick and tx_tick in the commit cycle; first rx_tick follows D+1 cycles later.
REQ-018 SHALL ignore writes with ioaddr 2'b00, and 2'b01 when the macro is absent.
REQ-019 SHALL update div_q in the cycle after commit; it is never the staging value.

Reset
REQ-020 SHALL, with rst high, set D=RESET_DIV, staging=RESET_DIV, counter=RESET_DIV, phase=0, rx_tick=0, tx_tick=0, fraction state=0.
REQ-021 SHALL give rst priority over a simultaneous wr_en; the write is lost.
REQ-022 SHALL, when rst is asserted mid-period, discard the partial period; first rx_tick is RESET_DIV+1 cycles after rst deasserts.

Configuration
REQ-023 SHALL, with BAUD_FRAC_EN defined, add a 4-bit fraction F written at ioaddr 2'b01 (wr_data[3:0]) that takes effect at the next commit; on each reload a 4-bit accumulator adds F, and carry-out extends that period to D+2 cycles, giving average D+1+F/16.
REQ-024 SHALL, without BAUD_FRAC_EN, contain no fraction register or accumulator, and 2'b01 writes have no effect.

Structure
REQ-025 SHALL place ioaddr encodings (BAUD_ADDR_LO, BAUD_ADDR_HI, BAUD_ADDR_FRAC) and standard divisor constants (4800/9600/19200/38400 at 50 MHz, OSR 16: 650, 325, 162, 80) in package baud_pkg.
REQ-026 SHALL isolate the OSR phase counter and tx_tick generation in sub-module baud_phase_cnt, parametrised by OSR.

Verification
REQ-027 SHALL check reset: rst 3 cycles, release -> rx_tick first at cycle 326, tx_tick first at cycle 5216, then every 326/5216.
REQ-028 SHALL check commit: write 2'b10=0x50, 2'b11=0x00 mid-period -> no tick on commit cycle, div_q=80, rx_tick every 81 cycles, tx_tick every 1296.
REQ-029 SHALL check staging: write 2'b10=0x05 only -> ticks remain at 326-cycle period, div_q=325.
REQ-030 SHALL check zero divisor: commit D=0 -> rx_tick continuous, tx_tick every 16 cycles.
REQ-031 SHALL check reset precedence: rst and wr_en 2'b11 in the same cycle -> div_q=325, period 326.
REQ-032 SHALL check BAUD_FRAC_EN: F=8, D=80 -> rx_tick periods alternate 81/82 cycles; 16 periods total 1304 cycles.
